// File: rtl/i2s_drain_pkg.sv
// Shared types and defaults for the I2S FIFO drain controller.
// Holds FSM encoding, default widths and a min() helper.
package i2s_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int AW_DEF    = 4;
  localparam int CW_DEF    = 16;
  localparam int TMO_W_DEF = 12;

  function automatic logic [31:0] min_u(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/i2s_drain_obuf.sv
// Single-entry valid/ready output register for the drain stream.
// Ports: load/din/last_in fill it, consume drains it, flush drops it.
module i2s_drain_obuf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          last_in,
  input  logic          consume,
  input  logic          flush,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          last
);

  logic          vld_q;
  logic [DW-1:0] dat_q;
  logic          lst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      lst_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
      lst_q <= 1'b0;
    end else if (load) begin
      // a load may replace a sample consumed this cycle
      vld_q <= 1'b1;
      dat_q <= din;
      lst_q <= last_in;
    end else if (vld_q && consume) begin
      vld_q <= 1'b0;
    end
  end

  assign valid = vld_q;
  assign data  = dat_q;
  assign last  = vld_q & lst_q;

endmodule

// File: rtl/i2s_fifo_drain_ctrl.sv
// Drains the I2S sample FIFO in bursts onto a valid/ready stream.
// Ports: FIFO pop side, m_* stream, busy/remaining/done/overrun status.
// Option: I2S_DRAIN_TIMEOUT_EN adds tmo_cycles (partial-burst timeout).
module i2s_fifo_drain_ctrl
  import i2s_drain_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = 32,
  parameter int CW    = CW_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic [CW-1:0] xfer_len,
  input  logic [AW-1:0] burst_len,
  input  logic [AW-1:0] fifo_level,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic [DW-1:0] fifo_rdata,
  output logic          fifo_rd,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic [CW-1:0] remaining,
  output logic          done,
  output logic          overrun,
  input  logic          overrun_clr
`ifdef I2S_DRAIN_TIMEOUT_EN
  ,input logic [TMO_W-1:0] tmo_cycles
`endif
);

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [AW-1:0] bctr_q, bctr_d;
  logic          done_q, done_d;
  logic          ovr_q;
  logic [AW-1:0] blen_eff;
  logic [31:0]   need;
  logic          level_ok;
  logic          pop;
  logic          tmo_hit;

  assign blen_eff = (burst_len == '0) ? AW'(1) : burst_len;
  assign need     = min_u(32'(blen_eff), 32'(rem_q));
  assign level_ok = fifo_full || (32'(fifo_level) >= need);

  // counters gate the pop so remaining can never underflow
  assign pop = en && (state_q == BURST) && !fifo_empty
            && (!m_valid || m_ready)
            && (rem_q != '0) && (bctr_q != '0);

`ifdef I2S_DRAIN_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q != WAIT || fifo_level == '0) begin
      tmo_q <= '0;
    end else if (32'(fifo_level) < need && tmo_q != '1) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == WAIT) && (tmo_cycles != '0)
                && (tmo_q >= tmo_cycles) && (fifo_level != '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      bctr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bctr_q  <= bctr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    bctr_d  = bctr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && en) begin
          if (xfer_len != '0) begin
            rem_d   = xfer_len;
            state_d = WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (level_ok) begin
          bctr_d  = AW'(need);
          state_d = BURST;
        end else if (tmo_hit) begin
          bctr_d  = fifo_level;
          state_d = BURST;
        end
      end
      BURST: begin
        if (pop) begin
          rem_d  = rem_q - 1'b1;
          bctr_d = bctr_q - 1'b1;
          if (rem_q == CW'(1)) begin
            state_d = DRAIN;
          end else if (bctr_q == AW'(1)) begin
            state_d = WAIT;
          end
        end
      end
      DRAIN: begin
        if (m_valid && m_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    if (!en) begin
      state_d = IDLE;
      rem_d   = '0;
      bctr_d  = '0;
      done_d  = 1'b0;
    end
  end

  // clear beats a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else if (overrun_clr) begin
      ovr_q <= 1'b0;
    end else if (fifo_full && state_q != IDLE) begin
      ovr_q <= 1'b1;
    end
  end

  i2s_drain_obuf #(
    .DW(DW)
  ) u_obuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pop),
    .din    (fifo_rdata),
    .last_in(rem_q == CW'(1)),
    .consume(m_ready),
    .flush  (!en),
    .valid  (m_valid),
    .data   (m_data),
    .last   (m_last)
  );

  assign fifo_rd   = pop;
  assign busy      = (state_q != IDLE);
  assign remaining = rem_q;
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_i2s_fifo_drain_ctrl.sv
// Self-checking bench for i2s_fifo_drain_ctrl.
// Bench plays the FIFO; a queue model predicts stream and status.
module tb_i2s_fifo_drain_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          start;
  logic [CW-1:0] xfer_len;
  logic [AW-1:0] burst_len;
  logic [AW-1:0] fifo_level;
  logic          fifo_empty;
  logic          fifo_full;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] remaining;
  logic          done;
  logic          overrun;
  logic          overrun_clr;
`ifdef I2S_DRAIN_TIMEOUT_EN
  logic [11:0]   tmo_cycles = '0;
`endif

  always #5 clk = ~clk;

  i2s_fifo_drain_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .start      (start),
    .xfer_len   (xfer_len),
    .burst_len  (burst_len),
    .fifo_level (fifo_level),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .remaining  (remaining),
    .done       (done),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`ifdef I2S_DRAIN_TIMEOUT_EN
    ,.tmo_cycles(tmo_cycles)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] ref_q[$];
  bit pend_pop = 0;
  bit mbusy = 0;
  bit movr = 0;
  int mrem = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_level = AW'(q.size());
    fifo_empty = (q.size() == 0);
    fifo_full  = (q.size() == DEPTH);
    fifo_rdata = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push_rand();
    logic [DW-1:0] d;
    d = $urandom;
    q.push_back(d);
    ref_q.push_back(d);
  endtask

  task automatic prefill(input int n);
    while (q.size() < n) begin
      @(negedge clk);
      push_rand();
      drive_fifo();
      overrun_clr = 1'b0;
    end
  endtask

  task automatic run_xfer(
    input int len,
    input int blen,
    input int push_pct,
    input int rdy_pct,
    input int abort_at
  );
    int cyc = 0;
    int got = 0;
    int bleft = 0;
    int need;
    bit fin = 0;
    bit exp_done = 0;
    bit stall_prev = 0;
    bit aborted = 0;
    bit ab_now;
    logic [DW-1:0] d_prev = '0;
    logic [DW-1:0] exp_d;
    xfer_len  = CW'(len);
    burst_len = AW'(blen);
    while (!fin) begin
      @(negedge clk);
      if (pend_pop) begin
        q.delete(0);
        pend_pop = 0;
      end
      if (q.size() < DEPTH && $urandom_range(99) < push_pct)
        push_rand();
      drive_fifo();
      start       = (cyc == 0);
      m_ready     = ($urandom_range(99) < rdy_pct);
      overrun_clr = (cyc == 1) || ($urandom_range(99) < 3);
      ab_now = 0;
      if (abort_at >= 0 && !aborted && got >= abort_at && m_valid) begin
        en      = 1'b0;
        m_ready = 1'b0;
        ab_now  = 1;
        aborted = 1;
      end
      #1;
      chk("done", done, exp_done);
      chk("busy", busy, mbusy);
      chk("rem", remaining, mrem);
      chk("ovr", overrun, movr);
      if (m_valid && !m_ready) begin
        chk("rd_stall", fifo_rd, 0);
        if (stall_prev) chk("hold", m_data, d_prev);
      end
      stall_prev = m_valid && !m_ready;
      d_prev = m_data;
      if (exp_done) fin = 1;
      if (aborted && !ab_now) begin
        chk("abort_mv", m_valid, 0);
        fin = 1;
      end
      exp_done = 0;
      movr = overrun_clr ? 1'b0 : ((fifo_full && mbusy) ? 1'b1 : movr);
      if (ab_now) begin
        chk("abort_rd", fifo_rd, 0);
        mbusy = 0;
        mrem  = 0;
      end else if (!fin) begin
        if (start && !mbusy) begin
          if (len != 0) begin
            mbusy = 1;
            mrem  = len;
          end else begin
            exp_done = 1;
          end
        end
        if (fifo_rd) begin
          chk("rd_over", mrem != 0, 1);
          if (bleft == 0) begin
            need = (blen == 0) ? 1 : blen;
            if (mrem < need) need = mrem;
            chk("lvl_ok", fifo_full || (int'(fifo_level) >= need), 1);
            bleft = need;
          end
          bleft--;
          mrem--;
          pend_pop = 1;
        end
        if (m_valid && m_ready) begin
          chk("data_avail", ref_q.size() != 0, 1);
          exp_d = (ref_q.size() != 0) ? ref_q.pop_front() : '0;
          chk("data", m_data, exp_d);
          chk("last", m_last, got == len - 1);
          got++;
          if (got == len) begin
            mbusy    = 0;
            exp_done = 1;
          end
        end
      end
      cyc++;
      if (cyc > 4000 && !fin) begin
        chk("timeout", 0, 1);
        fin = 1;
      end
    end
    @(negedge clk);
    if (pend_pop) begin
      q.delete(0);
      pend_pop = 0;
    end
    drive_fifo();
    en          = 1'b1;
    start       = 1'b0;
    m_ready     = 1'b0;
    overrun_clr = 1'b0;
    if (aborted) ref_q = q;
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    start       = 1'b0;
    xfer_len    = '0;
    burst_len   = '0;
    m_ready     = 1'b0;
    overrun_clr = 1'b0;
    drive_fifo();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd", fifo_rd, 0);
    chk("rst_mv", m_valid, 0);
    chk("rst_md", m_data, 0);
    chk("rst_ml", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    run_xfer(8, 4, 50, 100, -1);
    run_xfer(6, 4, 60, 100, -1);
    run_xfer(12, 4, 80, 50, -1);
    run_xfer(0, 3, 0, 100, -1);
    prefill(DEPTH);
    run_xfer(3, 1, 0, 100, -1);
    run_xfer(20, 4, 60, 70, 3);
    run_xfer(5, 0, 40, 90, -1);
    for (int i = 0; i < 25; i++) begin
      run_xfer($urandom_range(40, 1), $urandom_range(15, 0),
               $urandom_range(90, 20), $urandom_range(100, 30), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
